alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the LC-3 datapath ALU. It keeps the four single-cycle operations ADD, AND, NOT and PASSA, and adds three iterative shifts and an iterative multiply. Operands are captured under a START/BUSY/DONE handshake, and condition codes (N, Z, P, V) are registered alongside the result. It sits where the single-cycle ALU sat, between the register-file/SR2MUX outputs and the bus driver, and is sequenced by the control FSM.

## Interface
Parameters:
- WIDTH, 16, datapath width; power of two, ≥ 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only when BUSY=0.
- ALUK  in  3  opcode: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 SHL, 101 SHRL (logical), 110 SHRA (arithmetic), 111 MUL.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; shifts use B[SHAMT_W-1:0] only.
- BUSY  out  1  operation in progress; START ignored while high.
- DONE  out  1  one-cycle pulse; OUT and flags valid from this cycle.
- OUT  out  WIDTH  registered result; held until next DONE.
- N, Z, P  out  1 each  sign of OUT; exactly one high.
- V  out  1  signed overflow of last ADD; 0 for every other op.

## Operation
- States: IDLE, SHIFT, MUL.
- IDLE + START: latch ALUK, A, B. A/B changes afterwards have no effect until the next acceptance.
- ADD/AND/NOT/PASSA: OUT computed at the acceptance edge; DONE=1 next cycle; stay IDLE.
- ADD: OUT = (A+B) mod 2^WIDTH. V = (A[MSB]==B[MSB]) && (OUT[MSB]!=A[MSB]).
- SHL/SHRL/SHRA with amount k = B[SHAMT_W-1:0]:
  - k=0: OUT=A; DONE next cycle; stay IDLE.
  - k>0: enter SHIFT with a working copy of A and count=k. Each edge shifts the copy one bit and decrements count.
  - SHL and SHRL fill with 0; SHRA replicates the MSB.
  - The edge that takes count to 0 writes OUT, pulses DONE and returns to IDLE.
- MUL: shift-add over WIDTH steps. Each edge examines one multiplier bit, LSB first. OUT = low WIDTH bits of A*B; sign-agnostic, two's-complement wrap.
  - Enter MUL with count=WIDTH.
  - The edge that takes count to 0 writes OUT, pulses DONE and returns to IDLE.
- Flags update only on the DONE edge, from the new OUT: N=OUT[MSB]; Z=(OUT==0); P=!N&&!Z. V per ADD rule, else 0.
- OUT, N, Z, P, V are unchanged while BUSY=1.
- Reset values: OUT=0, N=0, Z=1, P=0, V=0, BUSY=0, DONE=0, state IDLE.
- RESET mid-operation: abort immediately. All outputs take their reset values on that edge, no DONE is produced, and the aborted operands are discarded.
- RESET and START in the same cycle: RESET wins; nothing is accepted.

## Timing
- Latency L counts edges from the acceptance edge to the edge asserting DONE (inclusive):
  - ADD/AND/NOT/PASSA: L=1.
  - Shift: L=k+1, or L=1 when k=0.
  - MUL: L=WIDTH+1 (17 cycles at WIDTH=16).
- BUSY is high from the edge after acceptance through the cycle before DONE. Single-cycle ops and k=0 shifts never raise BUSY.
- BUSY=0 during the DONE cycle, so START in that cycle is accepted. Back-to-back ops therefore reach one result per L cycles.
- START while BUSY=1 is dropped, not queued. The bench must see no extra DONE.
- DONE is exactly one cycle wide and never asserted in consecutive cycles by a single operation.

## Test plan
- After reset: OUT=0x0000, Z=1, N=P=V=0, BUSY=0, DONE=0.
- ADD A=0x7FFF, B=0x0001 → DONE 1 cycle after START; OUT=0x8000, N=1, V=1. Then ADD 0xFFFF+0x0001 → OUT=0x0000, Z=1, V=0.
- SHRA A=0x8000, B=0x0004 → BUSY for 4 cycles, DONE at L=5, OUT=0xF800, N=1. SHRL same operands → OUT=0x0800, P=1. SHL A=0x0001, B=0x0013 (k=3) → OUT=0x0008, L=4.
- MUL A=0x0003, B=0xFFFF → DONE at L=17, OUT=0xFFFD, N=1. MUL 0x0100×0x0100 → OUT=0x0000, Z=1.
- Issue MUL, then pulse START with ADD at cycle 5 → ADD ignored; single DONE at L=17. ADD issued in the DONE cycle → second DONE one cycle later.
- Issue MUL, assert RESET at cycle 3 after acceptance → next cycle OUT=0, Z=1, BUSY=0, and no DONE within 20 cycles. A subsequent PASSA A=0x1234 → OUT=0x1234, P=1 at L=1.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the control FSM and the sequential ALU.
// Carries the START/BUSY/DONE handshake, the operands and the registered result and flags.
// The master issues requests and the slave (the ALU) returns results.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             START;
  logic [2:0]       ALUK;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] OUT;
  logic             N;
  logic             Z;
  logic             P;
  logic             V;

  modport master (
    output START, ALUK, A, B,
    input  BUSY, DONE, OUT, N, Z, P, V
  );

  modport slave (
    input  START, ALUK, A, B,
    output BUSY, DONE, OUT, N, Z, P, V
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: ADD/AND/NOT/PASSA in one step, bit-serial shifts and shift-add multiply.
// Latency: 1 cycle for logic/add and zero shifts, k+1 for shifts by k, WIDTH+1 for MUL.
// START is accepted only while BUSY is low; requests seen while busy are dropped.
module alu_seq #(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       CLK,
  input  logic       RESET,
  alu_seq_if.slave   bus
);

  localparam int CW = SHAMT_W + 1;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_AND   = 3'b001,
    OP_NOT   = 3'b010,
    OP_PASSA = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHRL  = 3'b101,
    OP_SHRA  = 3'b110,
    OP_MUL   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_e;

  state_e           state, state_nxt;
  op_e              op;
  logic [WIDTH-1:0] work;     // shift working copy
  logic [WIDTH-1:0] mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier;   // multiplier, shifted right each step
  logic [WIDTH-1:0] acc;      // partial product
  logic [CW-1:0]    cnt;      // remaining steps
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             fin;
  logic             v_nxt;
  logic [SHAMT_W-1:0] k;

  assign k       = bus.B[SHAMT_W-1:0];
  assign sum     = bus.A + bus.B;
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign bus.BUSY = (state != S_IDLE);

  function automatic logic [WIDTH-1:0] shift1(input op_e o, input logic [WIDTH-1:0] w);
    case (o)
      OP_SHL:  return {w[WIDTH-2:0], 1'b0};
      OP_SHRA: return {w[WIDTH-1], w[WIDTH-1:1]};
      default: return {1'b0, w[WIDTH-1:1]};
    endcase
  endfunction

  // State register; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the result/overflow to be committed on a finishing edge.
  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    res       = '0;
    v_nxt     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.START) begin
          case (op_e'(bus.ALUK))
            OP_ADD: begin
              fin   = 1'b1;
              res   = sum;
              v_nxt = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: begin
              fin = 1'b1;
              res = bus.A & bus.B;
            end
            OP_NOT: begin
              fin = 1'b1;
              res = ~bus.A;
            end
            OP_PASSA: begin
              fin = 1'b1;
              res = bus.A;
            end
            OP_SHL, OP_SHRL, OP_SHRA: begin
              if (k == '0) begin
                fin = 1'b1;
                res = bus.A;
              end else begin
                state_nxt = S_SHIFT;
              end
            end
            default: state_nxt = S_MUL;
          endcase
        end
      end
      S_SHIFT: begin
        if (cnt == CW'(1)) begin
          fin       = 1'b1;
          res       = shift1(op, work);
          state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt == CW'(1)) begin
          fin       = 1'b1;
          res       = acc_nxt;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and per-step iteration of the shift/multiply working registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op     <= OP_ADD;
      work   <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            op     <= op_e'(bus.ALUK);
            work   <= bus.A;
            mcand  <= bus.A;
            mplier <= bus.B;
            acc    <= '0;
            cnt    <= (op_e'(bus.ALUK) == OP_MUL) ? CW'(WIDTH) : {1'b0, k};
          end
        end
        S_SHIFT: begin
          work <= shift1(op, work);
          cnt  <= cnt - CW'(1);
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - CW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Result, flags and DONE pulse; only a finishing edge changes the visible result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.OUT  <= '0;
      bus.N    <= 1'b0;
      bus.Z    <= 1'b1;
      bus.P    <= 1'b0;
      bus.V    <= 1'b0;
      bus.DONE <= 1'b0;
    end else begin
      bus.DONE <= fin;
      if (fin) begin
        bus.OUT <= res;
        bus.N   <= res[WIDTH-1];
        bus.Z   <= (res == '0);
        bus.P   <= !res[WIDTH-1] && (res != '0);
        bus.V   <= v_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed operations checked by literal expectations and a cycle model.
// The model predicts DONE/BUSY/OUT/flags from opcode semantics and latency rules.
// Inputs change 1 time unit after the rising edge; the model is compared on falling edges.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result from plain arithmetic, completion after L edges.
  int          rem = 0;
  logic [15:0] pend_out;
  logic        pend_v;
  logic [15:0] exp_out = 16'h0;
  logic        exp_v = 1'b0;
  logic        exp_done = 1'b0;
  logic        model_live = 1'b0;

  always @(posedge clk) begin
    int lat;
    int s;
    int kk;
    logic signed [15:0] sa;
    model_live = 1'b1;
    if (rst) begin
      rem = 0; exp_out = 16'h0; exp_v = 1'b0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          exp_out = pend_out; exp_v = pend_v; exp_done = 1'b1;
        end
      end else if (bus.START) begin
        kk = int'(bus.B[3:0]);
        sa = bus.A;
        pend_v = 1'b0;
        lat = 1;
        case (bus.ALUK)
          3'd0: begin
            pend_out = bus.A + bus.B;
            s = int'($signed(bus.A)) + int'($signed(bus.B));
            pend_v = (s > 32767) || (s < -32768);
          end
          3'd1: pend_out = bus.A & bus.B;
          3'd2: pend_out = ~bus.A;
          3'd3: pend_out = bus.A;
          3'd4: begin pend_out = bus.A << kk; lat = (kk == 0) ? 1 : kk + 1; end
          3'd5: begin pend_out = bus.A >> kk; lat = (kk == 0) ? 1 : kk + 1; end
          3'd6: begin pend_out = sa >>> kk;   lat = (kk == 0) ? 1 : kk + 1; end
          default: begin pend_out = bus.A * bus.B; lat = 17; end
        endcase
        if (lat == 1) begin
          exp_out = pend_out; exp_v = pend_v; exp_done = 1'b1;
        end else begin
          rem = lat - 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("done", bus.DONE, exp_done);
      chk("busy", bus.BUSY, rem > 0);
      chk("out", bus.OUT, exp_out);
      chk("flags_nzpv", {bus.N, bus.Z, bus.P, bus.V},
          {exp_out[15], exp_out == 16'h0, !exp_out[15] && exp_out != 16'h0, exp_v});
    end
  end

  // Issue one op and wait (bounded) for DONE; pin latency, result and flags.
  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int exp_l, input logic [15:0] exp_o,
                        input logic [3:0] exp_f);
    int lat;
    @(posedge clk); #1;
    bus.START = 1'b1; bus.ALUK = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.A = 16'hDEAD; bus.B = 16'hBEEF;
    lat = 1;
    while (!bus.DONE && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, exp_l);
    chk({name, "_out"}, bus.OUT, exp_o);
    chk({name, "_nzpv"}, {bus.N, bus.Z, bus.P, bus.V}, exp_f);
  endtask

  initial begin
    int lat;
    int ndone;
    bus.START = 1'b0; bus.ALUK = 3'd0; bus.A = 16'h0; bus.B = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", bus.OUT, 16'h0000);
    chk("rst_nzpv", {bus.N, bus.Z, bus.P, bus.V}, 4'b0100);
    chk("rst_busy_done", {bus.BUSY, bus.DONE}, 2'b00);
    rst = 1'b0;

    run_op("add_ovf",  3'd0, 16'h7FFF, 16'h0001, 1,  16'h8000, 4'b1001);
    run_op("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 1,  16'h0000, 4'b0100);
    run_op("and",      3'd1, 16'hF0F0, 16'h0FF0, 1,  16'h00F0, 4'b0010);
    run_op("not",      3'd2, 16'h00FF, 16'h0000, 1,  16'hFF00, 4'b1000);
    run_op("shra",     3'd6, 16'h8000, 16'h0004, 5,  16'hF800, 4'b1000);
    run_op("shrl",     3'd5, 16'h8000, 16'h0004, 5,  16'h0800, 4'b0010);
    run_op("shl_k3",   3'd4, 16'h0001, 16'h0013, 4,  16'h0008, 4'b0010);
    run_op("shl_k0",   3'd4, 16'h1234, 16'h0010, 1,  16'h1234, 4'b0010);
    run_op("shra_k15", 3'd6, 16'h4000, 16'h000F, 16, 16'h0000, 4'b0100);
    run_op("mul_neg",  3'd7, 16'h0003, 16'hFFFF, 17, 16'hFFFD, 4'b1000);
    run_op("mul_zero", 3'd7, 16'h0100, 16'h0100, 17, 16'h0000, 4'b0100);

    // START while busy is dropped; START in the DONE cycle is accepted.
    @(posedge clk); #1;
    bus.START = 1'b1; bus.ALUK = 3'd7; bus.A = 16'h0005; bus.B = 16'h0007;
    @(posedge clk); #1;
    bus.START = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    bus.START = 1'b1; bus.ALUK = 3'd0; bus.A = 16'h0001; bus.B = 16'h0001;
    @(posedge clk); #1;
    bus.START = 1'b0; lat++;
    chk("drop_busy", bus.BUSY, 1'b1);
    while (!bus.DONE && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("drop_lat", lat, 17);
    chk("drop_out", bus.OUT, 16'h0023);
    bus.START = 1'b1; bus.ALUK = 3'd0; bus.A = 16'h0002; bus.B = 16'h0003;
    @(posedge clk); #1;
    bus.START = 1'b0;
    chk("b2b_done", bus.DONE, 1'b1);
    chk("b2b_out", bus.OUT, 16'h0005);
    @(posedge clk); #1;
    chk("b2b_done_low", bus.DONE, 1'b0);

    // Reset in the middle of a multiply.
    bus.START = 1'b1; bus.ALUK = 3'd7; bus.A = 16'h0003; bus.B = 16'h0005;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out", bus.OUT, 16'h0000);
    chk("abort_nzpv", {bus.N, bus.Z, bus.P, bus.V}, 4'b0100);
    chk("abort_busy", bus.BUSY, 1'b0);
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.DONE) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("passa", 3'd3, 16'h1234, 16'h0000, 1, 16'h1234, 4'b0010);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
